ucsbece154b_mem_arbiter: RTL

Arbitrates the single SDRAM-controller read port among several block-fill requesters: instruction-cache demand fetch, data-cache fill and the instruction prefetcher. It sits between those requesters and the SDRAM controller. It grants one requester at a time, issues a block-aligned burst read, counts the returned beats and steers each word back to the owner. It also supports per-requester cancellation on pipeline flush without breaking the controller's burst.

---
 rtl/ucsbece154b_mem_arbiter.sv | 165 ++++++++++++++++
 1 files changed

// File: rtl/ucsbece154b_mem_arbiter.sv
// rtl/ucsbece154b_mem_arbiter.sv - burst-read arbiter between block-fill requesters and the SDRAM controller
// Optional MEMARB_RR_EN selects rotating priority; default is fixed priority with port 0 highest.
module ucsbece154b_mem_arbiter #(
  parameter int NUM_REQ     = 3,
  parameter int BLOCK_WORDS = 4,
  parameter int WORD_SIZE   = 32
) (
  input  logic                           clk,
  input  logic                           Reset,
  input  logic [NUM_REQ-1:0]             ReqValid,
  input  logic [32*NUM_REQ-1:0]          ReqAddr,
  input  logic [NUM_REQ-1:0]             ReqCancel,
  output logic [NUM_REQ-1:0]             Grant,
  output logic [NUM_REQ-1:0]             RespValid,
  output logic [WORD_SIZE-1:0]           RespData,
  output logic [$clog2(BLOCK_WORDS)-1:0] RespWordIdx,
  output logic                           RespLast,
  output logic [31:0]                    MemReadAddress,
  output logic                           MemReadRequest,
  input  logic [WORD_SIZE-1:0]           MemDataIn,
  input  logic                           MemDataReady,
  output logic                           Busy
);
  localparam int IDX_W = $clog2(BLOCK_WORDS);
  localparam int SEL_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam logic [31:0] OFF_MASK = 32'(BLOCK_WORDS * 4 - 1);

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_BURST} state_t;

  state_t               state_q, state_d;
  logic [NUM_REQ-1:0]   grant_q, grant_d;
  logic [NUM_REQ-1:0]   resp_valid_q, resp_valid_d;
  logic [WORD_SIZE-1:0] resp_data_q, resp_data_d;
  logic [IDX_W-1:0]     resp_idx_q, resp_idx_d;
  logic [IDX_W-1:0]     cnt_q, cnt_d;
  logic                 resp_last_q, resp_last_d;
  logic [31:0]          mem_addr_q, mem_addr_d;
  logic                 mem_req_q, mem_req_d;
  logic                 busy_q, busy_d;
  logic                 cancel_q, cancel_d;
  logic                 cancel_now;
  logic                 found;
  logic [SEL_W-1:0]     win, cand;
  logic [31:0]          req_addr [NUM_REQ];
`ifdef MEMARB_RR_EN
  logic [SEL_W-1:0]     ptr_q, ptr_d;
`endif

  for (genvar i = 0; i < NUM_REQ; i++) begin : g_addr
    assign req_addr[i] = ReqAddr[32*i +: 32];
  end

  // Winner search: from the rotating pointer with wrap, or from port 0.
  always_comb begin
    found = 1'b0;
    win   = '0;
    cand  = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
`ifdef MEMARB_RR_EN
      cand = SEL_W'((int'(ptr_q) + k) % NUM_REQ);
`else
      cand = SEL_W'(k);
`endif
      if (!found && ReqValid[cand]) begin
        found = 1'b1;
        win   = cand;
      end
    end
  end

  always_comb begin
    state_d      = state_q;
    grant_d      = grant_q;
    resp_valid_d = '0;
    resp_data_d  = resp_data_q;
    resp_idx_d   = resp_idx_q;
    resp_last_d  = 1'b0;
    mem_addr_d   = mem_addr_q;
    mem_req_d    = mem_req_q;
    cnt_d        = cnt_q;
    cancel_d     = cancel_q;
`ifdef MEMARB_RR_EN
    ptr_d        = ptr_q;
`endif
    // A flush on the owner's port suppresses the beat arriving in the same cycle.
    cancel_now   = cancel_q | (|(ReqCancel & grant_q));
    unique case (state_q)
      S_IDLE: begin
        if (found) begin
          mem_addr_d = req_addr[win] & ~OFF_MASK;
          grant_d    = NUM_REQ'(1) << win;
          mem_req_d  = 1'b1;
          cnt_d      = '0;
          cancel_d   = 1'b0;
          state_d    = S_REQ;
`ifdef MEMARB_RR_EN
          ptr_d      = (win == SEL_W'(NUM_REQ - 1)) ? '0 : win + 1'b1;
`endif
        end
      end
      S_REQ, S_BURST: begin
        cancel_d = cancel_now;
        if (MemDataReady) begin
          resp_data_d  = MemDataIn;
          resp_idx_d   = cnt_q;
          resp_valid_d = cancel_now ? '0 : grant_q;
          mem_req_d    = 1'b0;
          cnt_d        = cnt_q + 1'b1;
          if (state_q == S_BURST && cnt_q == IDX_W'(BLOCK_WORDS - 1)) begin
            resp_last_d = 1'b1;
            grant_d     = '0;
            state_d     = S_IDLE;
          end else begin
            state_d = S_BURST;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
    busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge clk or negedge Reset) begin
    if (!Reset) begin
      state_q      <= S_IDLE;
      grant_q      <= '0;
      resp_valid_q <= '0;
      resp_data_q  <= '0;
      resp_idx_q   <= '0;
      resp_last_q  <= 1'b0;
      mem_addr_q   <= '0;
      mem_req_q    <= 1'b0;
      cnt_q        <= '0;
      cancel_q     <= 1'b0;
      busy_q       <= 1'b0;
`ifdef MEMARB_RR_EN
      ptr_q        <= '0;
`endif
    end else begin
      state_q      <= state_d;
      grant_q      <= grant_d;
      resp_valid_q <= resp_valid_d;
      resp_data_q  <= resp_data_d;
      resp_idx_q   <= resp_idx_d;
      resp_last_q  <= resp_last_d;
      mem_addr_q   <= mem_addr_d;
      mem_req_q    <= mem_req_d;
      cnt_q        <= cnt_d;
      cancel_q     <= cancel_d;
      busy_q       <= busy_d;
`ifdef MEMARB_RR_EN
      ptr_q        <= ptr_d;
`endif
    end
  end

  assign Grant          = grant_q;
  assign RespValid      = resp_valid_q;
  assign RespData       = resp_data_q;
  assign RespWordIdx    = resp_idx_q;
  assign RespLast       = resp_last_q;
  assign MemReadAddress = mem_addr_q;
  assign MemReadRequest = mem_req_q;
  assign Busy           = busy_q;
endmodule
